// File: rtl/ticket_vending_fsm.sv
// Parametrised ticket vending controller: accumulates coin credit, dispenses one
// ticket at the configured price, refunds change or cancelled credit one unit per cycle.
module ticket_vending_fsm #(
  parameter int unsigned PRICE_UNITS  = 4,
  parameter int unsigned TEN_UNITS    = 1,
  parameter int unsigned TWENTY_UNITS = 2,
  parameter int unsigned CW           = 4,
  parameter int unsigned TW           = 8
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          ten,
  input  logic          twenty,
  input  logic          cancel,
  output logic          ready,
  output logic          bill,
  output logic          dispense,
  output logic          return_sig,
  output logic [CW-1:0] credit,
  output logic [TW-1:0] tickets_sold
);

  // One extra bit so credit + coin can be compared against the price without wrapping.
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BILL = 2'd1,
    DISP = 2'd2,
    RTN  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt;
  logic [TW-1:0] tickets_nxt;
  logic [SW-1:0] coin;
  logic [SW-1:0] sum;
  logic [SW-1:0] price;

  assign price = SW'(PRICE_UNITS);

  // Coin value; ten wins when both pulses arrive together.
  always_comb begin
    coin = '0;
    if (ten) begin
      coin = SW'(TEN_UNITS);
    end else if (twenty) begin
      coin = SW'(TWENTY_UNITS);
    end
    sum = SW'(credit) + coin;
  end

  // State, credit and ticket counter registers.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state        <= IDLE;
      credit       <= '0;
      tickets_sold <= '0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      tickets_sold <= tickets_nxt;
    end
  end

  // Next-state, next-credit and ticket counter update.
  always_comb begin
    state_nxt   = state;
    credit_nxt  = credit;
    tickets_nxt = tickets_sold;
    unique case (state)
      IDLE: begin
        if (coin != '0) begin
          if (coin >= price) begin
            state_nxt  = DISP;
            credit_nxt = CW'(coin - price);
          end else begin
            state_nxt  = BILL;
            credit_nxt = CW'(coin);
          end
        end
      end
      BILL: begin
        if (cancel) begin
          state_nxt = RTN;
        end else if (sum >= price) begin
          state_nxt  = DISP;
          credit_nxt = CW'(sum - price);
        end else begin
          credit_nxt = CW'(sum);
        end
      end
      DISP: begin
        if (tickets_sold != {TW{1'b1}}) begin
          tickets_nxt = tickets_sold + TW'(1);
        end
        state_nxt = (credit == '0) ? IDLE : RTN;
      end
      RTN: begin
        credit_nxt = credit - CW'(1);
        if (credit <= CW'(1)) begin
          state_nxt  = IDLE;
          credit_nxt = '0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    ready      = 1'b0;
    bill       = 1'b0;
    dispense   = 1'b0;
    return_sig = 1'b0;
    unique case (state)
      IDLE:    ready      = 1'b1;
      BILL:    bill       = 1'b1;
      DISP:    dispense   = 1'b1;
      RTN:     return_sig = 1'b1;
      default: ready      = 1'b0;
    endcase
  end

endmodule

// File: doc/ticket_vending_fsm.md
Name: ticket_vending_fsm

Overview:
Parametrised successor to the fixed-price ticket machine. It accepts single-cycle coin pulses ("ten", "twenty") and accumulates credit in 10-unit steps. When the credit reaches a configurable price it dispenses one ticket, then returns any change one unit per cycle. It adds a cancel/refund path and a saturating ticket counter, and sits between the coin acceptor front-end and the dispenser/refund actuators.

Parameters:
PRICE_UNITS, 4, ticket price in 10-unit steps (4 = 40); must be >= 1
TEN_UNITS, 1, credit added by a "ten" pulse
TWENTY_UNITS, 2, credit added by a "twenty" pulse
CW, 4, credit register width; must hold PRICE_UNITS-1+max(TEN_UNITS,TWENTY_UNITS)
TW, 8, ticket counter width

Ports:
clk  input  1  clock; all logic on rising edge
clear_n  input  1  synchronous, active-low reset
ten  input  1  one-cycle pulse: 10-unit coin inserted
twenty  input  1  one-cycle pulse: 20-unit coin inserted
cancel  input  1  one-cycle pulse: abort purchase, refund credit
ready  output  1  high in IDLE
bill  output  1  high in BILL (credit held, below price)
dispense  output  1  high for exactly one cycle per ticket
return_sig  output  1  high one cycle per refunded unit
credit  output  CW  current credit in units (registered)
tickets_sold  output  TW  tickets dispensed since reset, saturating

Behaviour:
- Reset: clear_n sampled low at a clock edge forces state IDLE, credit=0, tickets_sold=0. Outputs follow: ready=1, bill=0, dispense=0, return_sig=0. Reset has priority over all inputs in every state, including mid-DISP and mid-RTN.
- States: IDLE, BILL, DISP, RTN. Moore outputs decoded from the state register only: ready=IDLE, bill=BILL, dispense=DISP, return_sig=RTN.
- Coin value v: ten -> TEN_UNITS; else twenty -> TWENTY_UNITS; else 0. When ten and twenty are high in the same cycle, ten wins and twenty is dropped.
- IDLE:
  - v>0: sum = v. If sum>=PRICE_UNITS, go to DISP with credit = sum-PRICE_UNITS; otherwise go to BILL with credit = sum.
  - cancel in IDLE is ignored.
- BILL:
  - cancel=1: go to RTN. Credit is unchanged. Coins in the same cycle are ignored (cancel has priority).
  - Otherwise sum = credit+v. If sum>=PRICE_UNITS, go to DISP with credit = sum-PRICE_UNITS; otherwise stay in BILL with credit = sum.
- DISP (one cycle):
  - tickets_sold increments, saturating at all-ones.
  - Next state is IDLE if credit==0, else RTN.
  - Coins and cancel are ignored.
- RTN:
  - Each cycle credit decrements by 1. When credit==1 in the current cycle, the next state is IDLE (credit reaches 0).
  - return_sig is therefore high for exactly N consecutive cycles, where N is the credit on entry.
  - Coins and cancel are ignored.
- Latency: the coin that completes the price produces dispense in the very next cycle. The first return_sig follows dispense by one cycle.
- Credit never exceeds PRICE_UNITS-1 in BILL and never overflows CW. An illegal or unused state encoding recovers to IDLE with credit=0 on the next edge.
- Coins arriving outside IDLE/BILL are lost by design. Upstream holds or rejects them.

Test Plan:
- clear_n=0 for 2 cycles, random ten/twenty/cancel -> ready=1, credit=0, tickets_sold=0, dispense=0, return_sig=0.
- Default params; ten on 4 separate cycles -> bill=1 with credit 1,2,3; dispense=1 one cycle after the 4th ten; then ready=1, credit=0, tickets_sold=1, no return_sig.
- twenty, ten, twenty -> credit 2, then 3; next cycle DISP with credit=1; then return_sig=1 for one cycle; then IDLE, tickets_sold=1.
- ten, ten, cancel -> return_sig high 2 consecutive cycles, credit 2->1->0, IDLE; tickets_sold unchanged, dispense never asserted.
- ten&twenty same cycle from IDLE -> credit=1. In BILL, cancel&twenty same cycle -> RTN with credit=1, one return_sig pulse. Coin during DISP/RTN -> credit unaffected.
- clear_n=0 during RTN with credit=3 -> next cycle IDLE, credit=0, tickets_sold=0, return_sig=0. Separately, with TW=2, dispense 5 tickets -> tickets_sold saturates at 3.
